uart_rx_deserializer: RTL
=========================

# uart_rx_deserializer

Receive-side counterpart of the UART TX path: samples the asynchronous serial line `rx_in`, detects a start bit, and oversamples each bit with a majority vote. It shifts in an LSB-first data word, checks optional parity and the stop bit, and presents the parallel byte with a one-cycle `data_valid` pulse. It sits between the board-level RX pin and the system-side consumer of received bytes, and is clocked at `prescale` × baud rate.

## Interface
- `DATA_WIDTH`, 8, number of data bits per frame.
- `clk`  in  1  oversampling clock (prescale × baud).
- `rstn`  in  1  reset, asynchronous, active-low.
- `rx_in`  in  1  serial line; idles high; asynchronous to `clk`.
- `prescale`  in  6  oversampling ratio; legal values 8, 16, 32.
- `par_en`  in  1  1 = frame carries a parity bit after the data bits.
- `par_typ`  in  1  0 = even parity, 1 = odd parity.
- `p_data`  out  DATA_WIDTH  received word; holds its value until the next valid frame.
- `data_valid`  out  1  one-cycle pulse when `p_data` holds a good frame.
- `par_err`  out  1  parity mismatch on the last frame; held until the next start detect.
- `stp_err`  out  1  stop bit sampled 0 on the last frame; held until the next start detect.

## Operation
- Input path: `rx_in` passes through a 2-flop synchronizer. All logic below uses the synchronized value `rx_s`.
- Configuration latch: `prescale` (P), `par_en` and `par_typ` are latched on the start-detect cycle. Changes mid-frame have no effect on the frame in progress.
- Illegal prescale: any P other than 8, 16 or 32 is treated as 16.
- Counters:
  - `edge_cnt` counts 0..P-1 within a bit and wraps to 0 at P-1.
  - `bit_cnt` advances on each `edge_cnt` wrap.
- Sampling: each bit is sampled at `edge_cnt` = P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority, registered at `edge_cnt` = P/2+2.
- FSM states:
  - **IDLE**: `rx_s`=0 while armed → START. Set `edge_cnt`=0, clear `par_err`/`stp_err`.
  - **START**: at the decision point, bit=1 (glitch) → IDLE with no output. Bit=0 → DATA at the wrap.
  - **DATA**: each decided bit shifts in LSB-first. After DATA_WIDTH bits, go to PARITY if `par_en`, else STOP, at the wrap.
  - **PARITY**: at the decision, compute the expected bit as XOR of the data, inverted if `par_typ`=1. Set `par_err` if it mismatches. Go to STOP at the wrap.
  - **STOP**: at the decision, set `stp_err` if the stop bit is 0. On the next cycle the FSM returns to IDLE without waiting for the rest of the stop bit.
- Output on STOP exit:
  - If neither error is set: `p_data` ← shift register and `data_valid`=1 for that one cycle.
  - Otherwise: `p_data` is unchanged and `data_valid` stays 0.
- Re-arm after `stp_err`: IDLE disarms and waits for `rx_s`=1 before accepting a new start. This prevents a held-low (break) line from re-triggering.
- Reset mid-frame: all state is cleared immediately and the FSM enters IDLE, armed. The partial frame is discarded.

## Timing
- Reset values:
  - `p_data`=0, `data_valid`=0, `par_err`=0, `stp_err`=0.
  - FSM=IDLE, armed; counters=0; synchronizer flops=1.
- Start-detect cycle (T0): first cycle with `rx_s`=0 in IDLE. This is 2–3 clk after `rx_in` falls.
- Bit k (start bit = 0) occupies T0+k·P .. T0+k·P+P-1. Its decision is at T0+k·P+P/2+2.
- Let N = 1 + DATA_WIDTH + `par_en` + 1. `data_valid` asserts at T0+(N-1)·P+P/2+3.
  - Example: P=8, no parity: T0+79.
- Error flags update on their decision cycle + 1. They remain stable through the `data_valid` slot until the next T0.
- Back-to-back frames: a start bit arriving immediately after the stop bit is detected, because IDLE is re-entered at mid-stop-bit. Baud error up to ±P/4 clk over the frame is tolerated.

## Test plan
- **Basic frame:** P=8, `par_en`=0, frame 0xA5 with stop=1 → `data_valid` one pulse at T0+79, `p_data`=0xA5, `par_err`=`stp_err`=0.
- **Parity:** P=16, even parity.
  - 0x3C with parity bit 0 → `data_valid`, `p_data`=0x3C.
  - Repeat with parity bit 1 → `par_err`=1, no `data_valid`, `p_data` still 0x3C.
  - Odd parity at P=32 with 0x01 and parity bit 0 → valid.
- **Glitch rejection:** P=16, `rx_in` low for 3 clk then high → FSM returns to IDLE; no `data_valid`, no error flags; a following good frame 0x5A is received correctly.
- **Break and re-arm:** `rx_in` held low for 2 frame times → one frame with `p_data` unchanged and `stp_err`=1, then no further triggers while the line stays low; after the line goes high, frame 0xC3 is received correctly and `stp_err` clears at its T0.
- **Back-to-back with config change:** frames 0x00, 0xFF, 0x81 sent with no idle gap, P=8 → three `data_valid` pulses spaced 80 clk apart; `prescale` changed to 32 during frame 2 does not corrupt it.
- **Reset mid-frame:** `rstn` asserted during DATA bit 4 → all outputs 0 immediately; after release, the next frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_deserializer_if.sv
// rtl/uart_rx_deserializer_if.sv - received-word bundle from the UART receiver to its consumer
interface uart_rx_deserializer_if #(parameter int DATA_WIDTH = 8);
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;

   modport master (output p_data, data_valid, par_err, stp_err);
   modport slave  (input  p_data, data_valid, par_err, stp_err);
endinterface

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - oversampling UART receiver with 2-of-3 vote, parity and stop checks
module uart_rx_deserializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   i_rx_in,
   input  logic [5:0]             i_prescale,
   input  logic                   i_par_en,
   input  logic                   i_par_typ,
   uart_rx_deserializer_if.master o_rx
);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                r_state;
   logic                  r_sync1, r_sync2, r_armed;
   logic [5:0]            r_p, r_edge;
   logic [BW-1:0]         r_bit;
   logic [2:0]            r_samp;
   logic [DATA_WIDTH-1:0] r_shift, r_p_data;
   logic                  r_par_en, r_par_typ, r_valid, r_par_err, r_stp_err;

   logic [5:0] w_p, w_half;
   logic       w_rx_s, w_wrap, w_decide, w_maj, w_par_exp;

   always_comb begin
      w_p = 6'd16;
      case (i_prescale)
         6'd8, 6'd16, 6'd32: w_p = i_prescale;
         default:            w_p = 6'd16;
      endcase
   end

   assign w_rx_s    = r_sync2;
   assign w_half    = {1'b0, r_p[5:1]};
   assign w_wrap    = (r_edge == r_p - 6'd1);
   assign w_decide  = (r_edge == w_half + 6'd2);
   assign w_maj     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
   assign w_par_exp = (^r_shift) ^ r_par_typ;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_armed   <= 1'b1;
         r_p       <= 6'd16;
         r_edge    <= 6'd0;
         r_bit     <= '0;
         r_samp    <= 3'b111;
         r_shift   <= '0;
         r_p_data  <= '0;
         r_par_en  <= 1'b0;
         r_par_typ <= 1'b0;
         r_valid   <= 1'b0;
         r_par_err <= 1'b0;
         r_stp_err <= 1'b0;
      end else begin
         r_sync1 <= i_rx_in;
         r_sync2 <= r_sync1;
         r_valid <= 1'b0;
         if (r_state != S_IDLE) begin
            r_edge <= w_wrap ? 6'd0 : r_edge + 6'd1;
            if (r_edge == w_half - 6'd1) r_samp[0] <= w_rx_s;
            if (r_edge == w_half)        r_samp[1] <= w_rx_s;
            if (r_edge == w_half + 6'd1) r_samp[2] <= w_rx_s;
         end
         case (r_state)
            S_IDLE: begin
               if (w_rx_s) begin
                  r_armed <= 1'b1;
               end else if (r_armed) begin
                  // The detect cycle itself is edge 0 of the start bit, so counting resumes at 1.
                  r_state   <= S_START;
                  r_edge    <= 6'd1;
                  r_bit     <= '0;
                  r_par_err <= 1'b0;
                  r_stp_err <= 1'b0;
                  r_p       <= w_p;
                  r_par_en  <= i_par_en;
                  r_par_typ <= i_par_typ;
               end
            end
            S_START: begin
               if (w_decide && w_maj) begin
                  r_state <= S_IDLE;
                  r_edge  <= 6'd0;
               end else if (w_wrap) begin
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_decide) r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
               if (w_wrap) begin
                  if (r_bit == BW'(DATA_WIDTH - 1)) begin
                     r_bit   <= '0;
                     r_state <= r_par_en ? S_PARITY : S_STOP;
                  end else begin
                     r_bit <= r_bit + BW'(1);
                  end
               end
            end
            S_PARITY: begin
               if (w_decide) r_par_err <= (w_maj != w_par_exp);
               if (w_wrap)   r_state   <= S_STOP;
            end
            S_STOP: begin
               // Leave mid-stop-bit so a back-to-back start edge is not missed; a low stop disarms.
               if (w_decide) begin
                  r_state   <= S_IDLE;
                  r_edge    <= 6'd0;
                  r_stp_err <= !w_maj;
                  if (!w_maj) begin
                     r_armed <= 1'b0;
                  end else if (!r_par_err) begin
                     r_p_data <= r_shift;
                     r_valid  <= 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_rx.p_data     = r_p_data;
   assign o_rx.data_valid = r_valid;
   assign o_rx.par_err    = r_par_err;
   assign o_rx.stp_err    = r_stp_err;
endmodule
